rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one 8-way resource between 8 requesters.
- Selects one requester, holds its 3-bit grant index, and drives a one-hot 8-bit grant through an internal 3-to-8 decode stage.
- Inserts a dead cycle between owners so the one-hot grant is never two-hot.
- Sits between the requester set and the shared resource select lines.

Parameters:
- MAX_HOLD, 16, maximum consecutive BUSY cycles per grant. Used only when ARB_TIMEOUT_EN is defined; legal range 2..256.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  arbitration enable; gates new grants only
- req  in  8  request vector; req[i] high = requester i wants the resource
- gnt  out  8  one-hot grant, decoded from gnt_idx while gnt_valid is high, otherwise 8'h00
- gnt_idx  out  3  index of current owner, registered
- gnt_valid  out  1  high while in BUSY
- timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=0, gnt_idx=0, gnt=0, gnt_valid=0, timeout=0, hold_cnt=0. Deassertion takes effect at the next clk edge.
- All outputs are registered or decoded from registers. There is no combinational path from req to any output.
- FSM states: IDLE, BUSY, GAP.
- IDLE:
  - If en=1 and req!=0 at an edge: winner = first set req bit searching ptr, ptr+1, ... mod 8. Then gnt_idx<=winner, state<=BUSY, hold_cnt<=0.
  - Otherwise stay in IDLE.
  - Grant latency is 1 cycle: gnt is visible in the cycle after req is sampled.
- BUSY:
  - gnt_valid=1 and gnt=1<<gnt_idx.
  - Other req bits are ignored.
  - If req[gnt_idx]=0 at an edge: state<=GAP and ptr<=gnt_idx+1 (3-bit wrap, so 7->0).
  - Otherwise hold_cnt increments.
- GAP:
  - gnt=0 and gnt_valid=0 for exactly one cycle, then state<=IDLE.
  - Minimum spacing between grants is therefore 2 cycles with gnt=0.
- en=0 during BUSY does not revoke the grant. en only blocks the IDLE->BUSY transition.
- Simultaneous requests: ptr-ordered search only. There is no fixed priority.
- Request withdrawn in the same edge that IDLE arbitrates: the sampled value wins. A requester that drops before the edge is not granted.
- All 8 requests held continuously: grants rotate 0,1,...,7,0 as each owner releases.
- Reset mid-grant: gnt drops to 0 immediately (asynchronous) and ptr returns to 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In BUSY, if hold_cnt==MAX_HOLD-1 and req[gnt_idx] is still 1 at an edge, release is forced: state<=GAP, ptr<=gnt_idx+1, timeout<=1 for one cycle (the GAP cycle).
  - The requester must re-arbitrate and loses priority to the others.
- Undefined:
  - hold_cnt is absent.
  - timeout is tied to 0.
  - The grant is held until req drops.

Decomposition:
- Shared package arb_pkg:
  - state enum: IDLE=2'd0, BUSY=2'd1, GAP=2'd2
  - NUM_REQ=8
  - IDX_W=3
- One natural sub-module: grant_dec38, a combinational 3-to-8 one-hot decode with an enable input (enable = gnt_valid), instantiated once.
- The round-robin search is a function in the top module.

Test Plan:
- Reset/idle: rst_n=0 with req=8'hFF -> gnt=0, gnt_valid=0. After release with en=1: gnt=8'h01 one cycle after the first edge.
- Rotation: req=8'hFF held -> grant sequence idx 0..7 then 0. Each requester drops its own req after 3 BUSY cycles. Exactly one GAP cycle plus one IDLE cycle with gnt=0 between owners.
- Pointer wrap: ptr=6 (after granting 5), req=8'b0010_0001 -> grant idx 0, not 5. Then ptr=1 -> next grant idx 5.
- Enable gating: en=0 with req=8'h10 -> no grant. Raise en -> gnt=8'h10 next cycle. Drop en in BUSY -> grant held until req[4]=0.
- Async reset mid-grant: assert rst_n=0 between edges while gnt=8'h08 -> gnt=0 immediately. After release with req=8'h0C -> grant idx 2 (ptr=0).
- ARB_TIMEOUT_EN, MAX_HOLD=4: req[3] held high -> gnt=8'h08 for exactly 4 cycles, then timeout=1 for one cycle with gnt=0. With req=8'h88, the next grant is idx 7.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter slice.
// Contents: NUM_REQ / IDX_W sizing constants and the arbiter state enum.
package arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Requester-side bundle of the arbiter.
// Signals: en, req (requesters -> arbiter); gnt, gnt_idx, gnt_valid,
// timeout (arbiter -> requesters / resource select).
// Modports: master = requester set, slave = arbiter.
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic               en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               timeout;

    modport master (
        output en, req,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  en, req,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/grant_dec38.sv
// Combinational 3-to-8 one-hot decode with enable.
// Ports: en (decode enable), idx (3-bit index), dec_c (one-hot, 0 when en=0).
module grant_dec38
    import arb_pkg::*;
(
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] dec_c
);

    always_comb begin
        dec_c = '0;
        if (en) begin
            dec_c[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters sharing one resource.
// A winner is picked in IDLE searching from ptr upward, held in BUSY while
// its request stays high, and followed by one GAP cycle so the one-hot
// grant never overlaps between owners.
// Ports: clk, rst_n (async, active-low), bus (rr_arbiter8_if.slave:
// en, req in; gnt, gnt_idx, gnt_valid, timeout out).
// Parameter: MAX_HOLD (2..256), BUSY cycle limit per grant.
// Build option: define ARB_TIMEOUT_EN to force release after MAX_HOLD
// BUSY cycles with a one-cycle timeout pulse; otherwise timeout is 0 and
// a grant lasts until its request drops.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("rr_arbiter8: MAX_HOLD must be in 2..256");
    end

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_nxt;
    logic             gnt_valid_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned      HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              timeout_q, timeout_nxt;
`endif

    // First set request at or after ptr, wrapping modulo 8.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [IDX_W-1:0]   p
    );
        logic [IDX_W-1:0] cand;
        rr_pick = p;
        // Walk offsets downward so the smallest offset is the last hit.
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            cand = p + IDX_W'(i);
            if (r[cand]) begin
                rr_pick = cand;
            end
        end
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx_q <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt_idx_q <= gnt_idx_nxt;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_cnt_nxt;
            timeout_q <= timeout_nxt;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        gnt_idx_nxt  = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_nxt = hold_cnt;
        timeout_nxt  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (bus.en && (|bus.req)) begin
                    gnt_idx_nxt  = rr_pick(bus.req, ptr);
                    state_nxt    = BUSY;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_nxt = '0;
`endif
                end
            end
            BUSY: begin
                if (!bus.req[gnt_idx_q]) begin
                    state_nxt = GAP;
                    ptr_nxt   = gnt_idx_q + IDX_W'(1);
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt == HOLD_LAST) begin
                    // Forced release; the owner re-queues behind everyone else.
                    state_nxt   = GAP;
                    ptr_nxt     = gnt_idx_q + IDX_W'(1);
                    timeout_nxt = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
`endif
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign gnt_valid_c   = (state == BUSY);
    assign bus.gnt_valid = gnt_valid_c;
    assign bus.gnt_idx   = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

    grant_dec38 u_dec (
        .en    (gnt_valid_c),
        .idx   (gnt_idx_q),
        .dec_c (bus.gnt)
    );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a driver applies directed and random
// stimulus on the falling edge and pushes the reference model's expected
// outputs; a monitor pops and compares one entry per rising edge.
module tb_rr_arbiter8;
    import arb_pkg::*;

    localparam int unsigned TB_MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst_n;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       timeout;
    } exp_t;

    exp_t expq[$];
    int   hist[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: who owns the resource, where the search starts next,
    // and how many cycles of blackout remain after a release.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_last  = 0;
    int m_held  = 0;
    bit m_gap   = 1'b0;
    bit m_to    = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic e, input logic [7:0] r);
        if (!rst) begin
            m_owner = -1; m_ptr = 0; m_last = 0; m_held = 0; m_gap = 1'b0; m_to = 1'b0;
        end else if (m_owner >= 0) begin
            m_to = 1'b0;
            if (!r[m_owner]) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_gap = 1'b1;
            end else begin
`ifdef ARB_TIMEOUT_EN
                if (m_held == int'(TB_MAX_HOLD)) begin
                    m_ptr = (m_owner + 1) % 8; m_owner = -1; m_gap = 1'b1; m_to = 1'b1;
                end else
`endif
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (e && r != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (r[(m_ptr + k) % 8]) begin
                        m_owner = (m_ptr + k) % 8;
                        m_last  = m_owner;
                        m_held  = 1;
                        hist.push_back(m_owner);
                        break;
                    end
                end
            end
        end
    endtask

    // Apply one cycle of inputs, predict the post-edge outputs, wait a cycle.
    task automatic cyc(input logic rst, input logic e, input logic [7:0] r, input bit chk_async = 1'b0);
        exp_t x;
        rst_n   = rst;
        bus.en  = e;
        bus.req = r;
        model_step(rst, e, r);
        x.gnt     = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        x.idx     = 3'(m_last);
        x.valid   = (m_owner >= 0);
        x.timeout = m_to;
        expq.push_back(x);
        if (chk_async) begin
            #1;
            check("async_rst_gnt", 32'(bus.gnt), 32'h0);
            check("async_rst_valid", 32'(bus.gnt_valid), 32'h0);
        end
        @(negedge clk);
    endtask

    task automatic check_hist(input string nm, input int pos, input int want);
        check(nm, (pos < hist.size()) ? 32'(hist[pos]) : 32'hFFFF_FFFF, 32'(want));
    endtask

    // Monitor: one expected entry per rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got empty queue want entry at %0t", $time);
            end else begin
                x = expq.pop_front();
                check("gnt", 32'(bus.gnt), 32'(x.gnt));
                check("gnt_idx", 32'(bus.gnt_idx), 32'(x.idx));
                check("gnt_valid", 32'(bus.gnt_valid), 32'(x.valid));
                check("timeout", 32'(bus.timeout), 32'(x.timeout));
            end
        end
    end

    // Driver.
    initial begin
        logic [7:0] r;
        logic       e;

        // Reset with all requests high: nothing granted.
        repeat (3) cyc(1'b0, 1'b1, 8'hFF);

        // Rotation: everyone requests, each owner drops after 3 BUSY cycles.
        hist.delete();
        for (int c = 0; c < 46; c++) begin
            r = 8'hFF;
            if (m_owner >= 0 && m_held >= 3) r[m_owner] = 1'b0;
            cyc(1'b1, 1'b1, r);
        end
        for (int i = 0; i < 9; i++) check_hist("rotation_order", i, i % 8);
        repeat (2) cyc(1'b1, 1'b1, 8'h00);

        // Pointer wrap: after granting 5, bit 0 beats bit 5, then 5 follows.
        cyc(1'b0, 1'b1, 8'h00);
        hist.delete();
        repeat (3) cyc(1'b1, 1'b1, 8'h20);
        cyc(1'b1, 1'b1, 8'h00);
        repeat (4) cyc(1'b1, 1'b1, 8'h21);
        repeat (4) cyc(1'b1, 1'b1, 8'h20);
        check_hist("wrap_first", 0, 5);
        check_hist("wrap_skip5", 1, 0);
        check_hist("wrap_then5", 2, 5);
        cyc(1'b1, 1'b1, 8'h00);
        repeat (2) cyc(1'b1, 1'b1, 8'h00);

        // Enable gating: no grant while en=0; dropping en in BUSY keeps it.
        hist.delete();
        repeat (3) cyc(1'b1, 1'b0, 8'h10);
        check("en_gate_none", 32'(hist.size()), 32'd0);
        cyc(1'b1, 1'b1, 8'h10);
        repeat (4) cyc(1'b1, 1'b0, 8'h10);
        cyc(1'b1, 1'b0, 8'h00);
        repeat (2) cyc(1'b1, 1'b1, 8'h00);
        check("en_gate_count", 32'(hist.size()), 32'd1);
        check_hist("en_gate_idx", 0, 4);

        // Async reset mid-grant, then ptr back at 0.
        hist.delete();
        repeat (2) cyc(1'b1, 1'b1, 8'h08);
        check_hist("pre_rst_idx", 0, 3);
        cyc(1'b0, 1'b1, 8'h0C, 1'b1);
        cyc(1'b0, 1'b1, 8'h0C);
        repeat (3) cyc(1'b1, 1'b1, 8'h0C);
        check_hist("post_rst_idx", 1, 2);
        repeat (2) cyc(1'b1, 1'b1, 8'h00);

        // Long hold: forced release when the timeout feature is built in.
        cyc(1'b0, 1'b1, 8'h00);
        hist.delete();
        cyc(1'b1, 1'b1, 8'h08);
        repeat (12) cyc(1'b1, 1'b1, 8'h88);
        check_hist("hold_first", 0, 3);
`ifdef ARB_TIMEOUT_EN
        check_hist("timeout_next", 1, 7);
`else
        check("hold_no_release", 32'(hist.size()), 32'd1);
`endif
        repeat (3) cyc(1'b1, 1'b1, 8'h00);

        // Random traffic with sticky requests and occasional resets.
        r = 8'h00;
        for (int c = 0; c < 500; c++) begin
            r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 49) == 0) r = 8'hFF;
            e = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 149) == 0) cyc(1'b0, e, r, 1'b1);
            else cyc(1'b1, e, r);
        end

        check("sb_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
